uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200: serial bit rate.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port serial_in  input  1  asynchronous UART line, idle high.
REQ-006 SHALL have port data_out  output  8  received byte, LSB = first data bit on line.
REQ-007 SHALL have port data_out_valid  output  1  data_out holds an unconsumed byte.
REQ-008 SHALL have port data_out_ready  input  1  consumer accepts byte when high with data_out_valid.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-010 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer), SAMPLE_TIME = SYMBOL_EDGE_TIME/2; clock counter width $clog2(SYMBOL_EDGE_TIME).
REQ-011 SHALL pass serial_in through a two-flop synchronizer, reset value 1; all logic uses the synchronized signal (rx_s).
REQ-012 SHALL implement states IDLE, START, DATA, STOP; reset state IDLE.
REQ-013 IDLE: rx_s == 0 -> START, clock counter cleared.
REQ-014 START: at counter == SAMPLE_TIME-1 sample rx_s; 0 -> DATA, counter cleared, bit index 0; 1 -> IDLE (false start, nothing reported).
REQ-015 DATA: at counter == SYMBOL_EDGE_TIME-1 shift rx_s into bit[index], LSB first, clear counter; after bit index 7 -> STOP.
REQ-016 STOP: at counter == SYMBOL_EDGE_TIME-1 sample stop bit, -> IDLE same edge; byte complete on that edge.
REQ-017 On byte completion with data_out_valid low, or high with data_out_ready high that cycle: load data_out and assert data_out_valid next cycle.
REQ-018 On byte completion with data_out_valid high and data_out_ready low: keep old data_out, drop new byte, pulse overrun one cycle.
REQ-019 data_out_valid SHALL clear the cycle after data_out_valid && data_out_ready unless REQ-017 reloads in the same cycle; data_out stable while valid high.
REQ-020 Receive path SHALL never stall on backpressure; a new start bit is accepted in IDLE regardless of data_out_valid.
REQ-021 Without framing check (REQ-027), a stop bit sampled 0 SHALL still complete the byte normally.

Reset
REQ-022 reset SHALL asynchronously force state IDLE, counters 0, synchronizer flops 1, data_out 8'h00, data_out_valid 0, overrun 0 (framing_error 0 when present).
REQ-023 reset mid-frame SHALL discard the partial byte; first frame after release is received correctly only if its start edge follows release.
REQ-024 A pending unconsumed byte SHALL be lost on reset.

Configuration
REQ-025 Macro UART_RX_FRAMING_CHECK_EN SHALL compile in port framing_error  output  1.
REQ-026 Without the macro, the port and its logic SHALL be absent.
REQ-027 With the macro: stop bit sampled 0 -> byte dropped (no valid), framing_error pulses one cycle, FSM still returns to IDLE; stop bit 1 -> behaviour per REQ-017/018.

Structure
REQ-028 Package uart_pkg SHALL hold FSM state typedef (one-hot, 4 bits) and DATA_BITS = 8 constant.
REQ-029 Synchronizer SHALL be sub-module uart_rx_sync (2-flop, reset value parameter, default 1).
REQ-030 Counter arithmetic SHALL use comparisons free of width-truncation at SYMBOL_EDGE_TIME = 1085.

Verification (CLOCK_FREQ=125_000_000, BAUD_RATE=115_200, 1085 clk/bit, mid-sample 542)
REQ-031 Frame 0xA5 (8N1, 1085 clk/bit) with data_out_ready=1 -> data_out=8'hA5, data_out_valid high exactly one cycle.
REQ-032 Low glitch of 200 cycles on idle line -> no data_out_valid, FSM back to IDLE by cycle 545.
REQ-033 Bytes 0x3C then 0x7E back-to-back, data_out_ready=0 -> data_out=8'h3C held, overrun pulses once at second stop; after ready, 0x3C consumed, valid low.
REQ-034 Frame 0x55 with stop bit 0: macro on -> framing_error one pulse, no valid; macro off -> data_out=8'h55 valid.
REQ-035 reset asserted mid DATA of 0xFF, released, then frame 0x81 -> only 0x81 delivered.
REQ-036 Loopback from transmitter sending 0x00, 0xFF, 0x5A with baud +2% -> all three received correctly, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t : one-hot receiver FSM state (4 bits)
//   DATA_BITS  : data bits per frame (8N1 framing)
//   cnt_width  : width helper for the bit-timing counter
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } rx_state_t;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing the asynchronous UART line into the clk
// domain. Both flops reset to RESET_VALUE so an idle-high line produces no
// spurious start edge when reset is released.
// Ports:
//   clk      : sampling clock
//   reset    : asynchronous, active-high reset
//   async_in : asynchronous input
//   sync_out : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic meta_r;
   logic sync_r;

   // Two-stage shift register; the first stage may go metastable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= RESET_VALUE;
         sync_r <= RESET_VALUE;
      end else begin
         meta_r <= async_in;
         sync_r <= meta_r;
      end
   end

   assign sync_out = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with a valid/ready byte output. The receive path never
// stalls: a byte completed while the previous one is still unconsumed is
// dropped and reported with a one-cycle overrun pulse.
//
// Parameters:
//   CLOCK_FREQ : clk frequency in Hz
//   BAUD_RATE  : serial bit rate
// Ports:
//   clk            : sole clock, rising edge
//   reset          : asynchronous, active-high reset
//   serial_in      : asynchronous UART line, idle high
//   data_out       : received byte, LSB = first data bit on the line
//   data_out_valid : data_out holds an unconsumed byte
//   data_out_ready : consumer takes the byte when high with data_out_valid
//   overrun        : one-cycle pulse when a completed byte is dropped
//   framing_error  : (only with UART_RX_FRAMING_CHECK_EN) one-cycle pulse
//                    when a stop bit is sampled low; that byte is dropped
//
// Optional feature macro: UART_RX_FRAMING_CHECK_EN
// -----------------------------------------------------------------------------
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_out_valid,
   input  logic                 data_out_ready,
   output logic                 overrun
`ifdef UART_RX_FRAMING_CHECK_EN
   ,
   output logic                 framing_error
`endif
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int CNT_W            = cnt_width(SYMBOL_EDGE_TIME);
   localparam int IDX_W            = cnt_width(DATA_BITS);

   // Terminal counts are computed in full integer precision and then sized to
   // the counter, so the equality compares never lose high-order bits.
   localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_t            state_r;
   rx_state_t            state_next_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [IDX_W-1:0]     bit_idx_r;
   logic [DATA_BITS-1:0] shift_r;

   logic sample_hit_s;
   logic symbol_hit_s;
   logic cnt_clr_s;
   logic cnt_inc_s;
   logic idx_clr_s;
   logic bit_load_s;
   logic stop_sample_s;
   logic byte_ok_s;
   logic accept_s;
   logic drop_s;

   logic [DATA_BITS-1:0] data_out_r;
   logic                 data_out_valid_r;
   logic                 overrun_r;

   uart_rx_sync #(
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (serial_in),
      .sync_out (rx_s)
   );

   assign sample_hit_s = (cnt_r == SAMPLE_LAST);
   assign symbol_hit_s = (cnt_r == SYMBOL_LAST);

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!rx_s) begin
               state_next_s = START;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            // A line that is high again at mid start bit was only a glitch.
            if (sample_hit_s) begin
               if (rx_s) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = DATA;
               end
            end else begin
               state_next_s = START;
            end
         end
         DATA: begin
            if (symbol_hit_s && (bit_idx_r == LAST_IDX)) begin
               state_next_s = STOP;
            end else begin
               state_next_s = DATA;
            end
         end
         STOP: begin
            if (symbol_hit_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = STOP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM outputs: datapath controls for the counter, bit index and sampling.
   always_comb begin
      cnt_clr_s     = 1'b0;
      cnt_inc_s     = 1'b0;
      idx_clr_s     = 1'b0;
      bit_load_s    = 1'b0;
      stop_sample_s = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_clr_s = 1'b1;
            idx_clr_s = 1'b1;
         end
         START: begin
            // After mid start bit, each further sample lands one full
            // symbol later, i.e. in the middle of the next bit.
            if (sample_hit_s) begin
               cnt_clr_s = 1'b1;
               idx_clr_s = 1'b1;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         DATA: begin
            if (symbol_hit_s) begin
               cnt_clr_s  = 1'b1;
               bit_load_s = 1'b1;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         STOP: begin
            if (symbol_hit_s) begin
               cnt_clr_s     = 1'b1;
               stop_sample_s = 1'b1;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         default: begin
            cnt_clr_s = 1'b1;
            idx_clr_s = 1'b1;
         end
      endcase
   end

   // Bit-timing counter, bit index and data shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r     <= {CNT_W{1'b0}};
         bit_idx_r <= {IDX_W{1'b0}};
         shift_r   <= {DATA_BITS{1'b0}};
      end else begin
         if (cnt_clr_s) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (idx_clr_s) begin
            bit_idx_r <= {IDX_W{1'b0}};
         end else if (bit_load_s) begin
            bit_idx_r <= bit_idx_r + IDX_W'(1);
         end
         if (bit_load_s) begin
            shift_r[bit_idx_r] <= rx_s;
         end
      end
   end

`ifdef UART_RX_FRAMING_CHECK_EN
   logic framing_error_r;

   assign byte_ok_s = stop_sample_s & rx_s;

   // Framing error pulse: stop bit sampled low, byte discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         framing_error_r <= 1'b0;
      end else begin
         framing_error_r <= stop_sample_s & ~rx_s;
      end
   end

   assign framing_error = framing_error_r;
`else
   // Without the framing check the stop bit level is not inspected.
   assign byte_ok_s = stop_sample_s;
`endif

   assign accept_s = byte_ok_s & (~data_out_valid_r | data_out_ready);
   assign drop_s   = byte_ok_s & data_out_valid_r & ~data_out_ready;

   // Output holding register with valid/ready handshake and overrun pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_r       <= {DATA_BITS{1'b0}};
         data_out_valid_r <= 1'b0;
         overrun_r        <= 1'b0;
      end else begin
         // A byte arriving on the very cycle the old one is taken replaces it.
         if (accept_s) begin
            data_out_r       <= shift_r;
            data_out_valid_r <= 1'b1;
         end else if (data_out_valid_r && data_out_ready) begin
            data_out_valid_r <= 1'b0;
         end
         overrun_r <= drop_s;
      end
   end

   assign data_out       = data_out_r;
   assign data_out_valid = data_out_valid_r;
   assign overrun        = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed plus randomized frames for uart_receiver. The DUT runs with a short
// bit period (131 clk/bit, mid-sample 65) so the whole sequence stays small;
// 131 lies just above a power of two, so the terminal-count compares still
// need the full counter width. Expected bytes come from the 8N1 framing rules
// applied to the bytes the bench transmits.
// Build with +define+UART_RX_FRAMING_CHECK_EN to exercise the framing check.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

   localparam int CLK_HZ = 131_000_000;
   localparam int BAUD   = 1_000_000;
   localparam int BIT_T  = CLK_HZ / BAUD;            // 131 clk per bit
   localparam int FAST_T = 128;                      // about 2 % fast

   logic       clk            = 1'b0;
   logic       reset          = 1'b1;
   logic       serial_in      = 1'b1;
   logic       data_out_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       overrun;
`ifdef UART_RX_FRAMING_CHECK_EN
   logic       framing_error;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor state (written only by the monitor process).
   logic [7:0] got_mem [0:255];
   int         got_cnt   = 0;
   int         valid_hi  = 0;
   int         ovr_hi    = 0;
   int         fe_hi     = 0;
   int         unstable  = 0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Reference model: bytes expected at the consumer since the last check.
   logic [7:0] exp_q [$];
   int         got_base = 0;

   always #5 clk = ~clk;

   uart_receiver #(
      .CLOCK_FREQ (CLK_HZ),
      .BAUD_RATE  (BAUD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .serial_in      (serial_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .overrun        (overrun)
`ifdef UART_RX_FRAMING_CHECK_EN
      ,
      .framing_error  (framing_error)
`endif
   );

   // Monitor: record handshakes, pulse widths and data stability mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         prev_hold <= 1'b0;
      end else begin
         if (data_out_valid) valid_hi <= valid_hi + 1;
         if (overrun) ovr_hi <= ovr_hi + 1;
`ifdef UART_RX_FRAMING_CHECK_EN
         if (framing_error) fe_hi <= fe_hi + 1;
`endif
         if (data_out_valid && data_out_ready) begin
            got_mem[got_cnt[7:0]] <= data_out;
            got_cnt <= got_cnt + 1;
         end
         if (prev_hold && data_out_valid && (data_out !== prev_data))
            unstable <= unstable + 1;
         prev_hold <= data_out_valid && !data_out_ready;
         prev_data <= data_out;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // 8N1 transmitter. A low stop bit is held for only 3/4 of a bit so the
   // line's return to idle is not timed like a fresh start bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period);
      serial_in = 1'b0;
      tick(period);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         tick(period);
      end
      serial_in = stop_bit;
      if (stop_bit) begin
         tick(period);
      end else begin
         tick((period * 3) / 4);
      end
      serial_in = 1'b1;
   endtask

   // Framing rule: a low stop bit loses the byte only when the check is built in.
   function automatic bit frame_delivers(input logic stop_bit);
`ifdef UART_RX_FRAMING_CHECK_EN
      return stop_bit;
`else
      return 1'b1;
`endif
   endfunction

   // Compare bytes received since the previous call against the model queue.
   task automatic check_stream(input string tag);
      int n;
      n = got_cnt - got_base;
      check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++)
         check({tag, "_byte"}, 32'(got_mem[8'(got_base + i)]), 32'(exp_q[i]));
      got_base = got_cnt;
      exp_q.delete();
   endtask

   initial begin
      int ovr_base;
      int vh_base;
      int fe_base;
      logic [7:0] rb;
      int rp;

      // Reset state
      tick(4);
      check("rst_data", 32'(data_out), 32'h00);
      check("rst_valid", 32'(data_out_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
`ifdef UART_RX_FRAMING_CHECK_EN
      check("rst_framing", 32'(framing_error), 32'h0);
`endif
      reset = 1'b0;
      tick(10);

      // 0xA5 with ready high: delivered, valid high exactly one cycle
      data_out_ready = 1'b1;
      vh_base = valid_hi;
      send_frame(8'hA5, 1'b1, BIT_T);
      exp_q.push_back(8'hA5);
      tick(5);
      check_stream("a5");
      check("a5_valid_cycles", 32'(valid_hi - vh_base), 32'd1);

      // Short low glitch: rejected at mid start bit, FSM idle again within
      // three cycles of the sample point, proven by a frame right behind it.
      serial_in = 1'b0;
      tick(24);
      serial_in = 1'b1;
      tick(44);
      check("glitch_no_valid", 32'(got_cnt - got_base), 32'd0);
      send_frame(8'hC3, 1'b1, BIT_T);
      exp_q.push_back(8'hC3);
      tick(5);
      check_stream("after_glitch");

      // 0x3C then 0x7E back-to-back with ready low: first held, second dropped
      data_out_ready = 1'b0;
      ovr_base = ovr_hi;
      send_frame(8'h3C, 1'b1, BIT_T);
      send_frame(8'h7E, 1'b1, BIT_T);
      tick(5);
      check("bp_data_held", 32'(data_out), 32'h3C);
      check("bp_valid", 32'(data_out_valid), 32'h1);
      check("bp_overrun_once", 32'(ovr_hi - ovr_base), 32'd1);
      data_out_ready = 1'b1;
      tick(1);
      data_out_ready = 1'b0;
      tick(3);
      check("bp_valid_cleared", 32'(data_out_valid), 32'h0);
      exp_q.push_back(8'h3C);
      check_stream("bp");

      // 0x55 with a low stop bit
      data_out_ready = 1'b1;
      fe_base = fe_hi;
      send_frame(8'h55, 1'b0, BIT_T);
      tick(2 * BIT_T);
      if (frame_delivers(1'b0)) exp_q.push_back(8'h55);
      check_stream("stop0");
`ifdef UART_RX_FRAMING_CHECK_EN
      check("stop0_framing_pulse", 32'(fe_hi - fe_base), 32'd1);
`endif

      // Pending byte plus reset in the middle of 0xFF's data bits
      data_out_ready = 1'b0;
      send_frame(8'h42, 1'b1, BIT_T);
      tick(5);
      check("pend_valid", 32'(data_out_valid), 32'h1);
      serial_in = 1'b0;
      tick(BIT_T);
      serial_in = 1'b1;
      tick(3 * BIT_T);
      reset = 1'b1;
      tick(3);
      check("mid_rst_valid", 32'(data_out_valid), 32'h0);
      check("mid_rst_data", 32'(data_out), 32'h00);
      reset = 1'b0;
      tick(BIT_T);
      data_out_ready = 1'b1;
      send_frame(8'h81, 1'b1, BIT_T);
      tick(5);
      exp_q.push_back(8'h81);
      check_stream("after_reset");

      // Transmitter about 2 % fast, frames back-to-back
      ovr_base = ovr_hi;
      send_frame(8'h00, 1'b1, FAST_T);
      send_frame(8'hFF, 1'b1, FAST_T);
      send_frame(8'h5A, 1'b1, FAST_T);
      tick(5);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h5A);
      check_stream("fast");
      check("fast_no_overrun", 32'(ovr_hi - ovr_base), 32'd0);

      // Random bytes, bit periods within +/-2 %, random idle gaps
      for (int k = 0; k < 10; k++) begin
         rb = 8'($urandom_range(0, 255));
         rp = int'($urandom_range(128, 134));
         send_frame(rb, 1'b1, rp);
         exp_q.push_back(rb);
         tick(int'($urandom_range(0, 20)));
      end
      tick(5);
      check_stream("random");

      // Whole-run properties
      check("total_overrun_cycles", 32'(ovr_hi), 32'd1);
      check("data_stable_while_held", 32'(unstable), 32'd0);
`ifdef UART_RX_FRAMING_CHECK_EN
      check("total_framing_cycles", 32'(fe_hi), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
